vend_ctrl: RTL



---
 rtl/vend_pkg.sv | 36 +++
 rtl/vend_cmp.sv | 20 ++
 rtl/vend_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencer.
package vend_pkg;

    // Sequencer states; IDLE always implies zero credit.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        RETURN = 2'd3
    } state_t;

    // Coin values in 5-cent units.
    localparam int unsigned NICKEL_U  = 1;
    localparam int unsigned DIME_U    = 2;
    localparam int unsigned QUARTER_U = 5;

    // Width able to hold the largest single coin value.
    localparam int unsigned COIN_W = 3;

    // Value of the coin presented; only meaningful when exactly one input is high.
    function automatic logic [COIN_W-1:0] coin_units(input logic nickel,
                                                     input logic dime,
                                                     input logic quarter);
        logic [COIN_W-1:0] units;
        units = '0;
        if (nickel) begin
            units = COIN_W'(NICKEL_U);
        end else if (dime) begin
            units = COIN_W'(DIME_U);
        end else if (quarter) begin
            units = COIN_W'(QUARTER_U);
        end
        return units;
    endfunction

endpackage

// File: rtl/vend_cmp.sv
// Credit-versus-price comparator, built as a subtract with borrow-out.
module vend_cmp #(
    parameter int unsigned W           = 4,
    parameter int unsigned PRICE_UNITS = 4
) (
    input  logic [W-1:0] credit,
    output logic         ge,
    output logic         eq
);

    logic [W:0] diff;

    // A clear borrow bit means credit covers the price; zero difference is exact payment.
    always_comb begin
        diff = {1'b0, credit} - (W+1)'(PRICE_UNITS);
        ge   = ~diff[W];
        eq   = (diff == '0);
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending sequencer: accumulates coin credit, dispenses, then pays change one nickel per cycle.
module vend_ctrl #(
    parameter int unsigned PRICE_UNITS = 4,
    parameter int unsigned SUM_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_nickel,
    input  logic             i_dime,
    input  logic             i_quarter,
    input  logic             i_cancel,
    output logic             o_soda,
    output logic             o_change_nickel,
    output logic [SUM_W-1:0] o_change,
    output logic [SUM_W-1:0] o_credit,
    output logic             o_coin_reject,
    output logic             o_busy
);

    import vend_pkg::*;

    localparam int unsigned ADD_W = SUM_W + 1;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   credit_q, credit_d;
    logic [SUM_W-1:0]   count_q, count_d;
    logic [SUM_W-1:0]   change_q, change_d;
    logic               soda_d, nickel_d, reject_d, busy_d;

    logic [1:0]         coin_cnt;
    logic               coin_one;
    logic               coin_any;
    logic [ADD_W-1:0]   coin_val;
    logic [ADD_W-1:0]   credit_sum;
    logic               cmp_ge;
    logic               cmp_eq;

    vend_cmp #(
        .W           (SUM_W),
        .PRICE_UNITS (PRICE_UNITS)
    ) u_cmp (
        .credit (credit_q),
        .ge     (cmp_ge),
        .eq     (cmp_eq)
    );

    // Coin decode and the widened credit adder.
    always_comb begin
        coin_cnt   = 2'(i_nickel) + 2'(i_dime) + 2'(i_quarter);
        coin_one   = (coin_cnt == 2'd1);
        coin_any   = (coin_cnt != 2'd0);
        coin_val   = ADD_W'(coin_units(i_nickel, i_dime, i_quarter));
        credit_sum = {1'b0, credit_q} + coin_val;
    end

    // Next-state, datapath and registered-output decisions.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        count_d  = count_q;
        change_d = change_q;
        reject_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (coin_one) begin
                    credit_d = SUM_W'(credit_sum);
                    state_d  = ACCUM;
                end else begin
                    reject_d = coin_any;
                end
            end

            ACCUM: begin
                if (cmp_ge) begin
                    // Price reached: vend takes priority over cancel, and further
                    // coins are refused so credit stays within PRICE_UNITS-1+5.
                    state_d  = VEND;
                    reject_d = coin_any;
                end else if (i_cancel && (credit_q != '0)) begin
                    count_d  = credit_q;
                    change_d = credit_q;
                    credit_d = '0;
                    state_d  = RETURN;
                    reject_d = coin_any;
                end else if (coin_one) begin
                    credit_d = SUM_W'(credit_sum);
                end else begin
                    reject_d = coin_any;
                end
            end

            VEND: begin
                count_d  = credit_q - SUM_W'(PRICE_UNITS);
                change_d = credit_q - SUM_W'(PRICE_UNITS);
                credit_d = '0;
                state_d  = cmp_eq ? IDLE : RETURN;
                reject_d = coin_any;
            end

            RETURN: begin
                count_d  = count_q - SUM_W'(1);
                reject_d = coin_any;
                if (count_q <= SUM_W'(1)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        soda_d   = (state_d == VEND);
        nickel_d = (state_d == RETURN);
        busy_d   = soda_d | nickel_d;
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= IDLE;
            credit_q        <= '0;
            count_q         <= '0;
            change_q        <= '0;
            o_soda          <= 1'b0;
            o_change_nickel <= 1'b0;
            o_coin_reject   <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            count_q         <= count_d;
            change_q        <= change_d;
            o_soda          <= soda_d;
            o_change_nickel <= nickel_d;
            o_coin_reject   <= reject_d;
            o_busy          <= busy_d;
        end
    end

    assign o_credit = credit_q;
    assign o_change = change_q;

endmodule
